// File: rtl/dx_multdiv_ctrl.sv
// DX-stage control: opcode decode, mult/div start/busy/done sequencing with a watchdog,
// pipeline stall generation and rstatus exception code selection.
module dx_multdiv_ctrl #(
    parameter int DATA_W     = 32,
    parameter int EXC_ADD    = 1,
    parameter int EXC_ADDI   = 2,
    parameter int EXC_SUB    = 3,
    parameter int EXC_MUL    = 4,
    parameter int EXC_DIV    = 5,
    parameter int MD_TIMEOUT = 64
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_instr_dx,
    input  logic              i_dx_valid,
    input  logic              i_kill,
    input  logic              i_alu_ovf,
    input  logic              i_md_rdy,
    input  logic              i_md_exc,
    output logic              o_immediate,
    output logic              o_j_extend,
    output logic              o_write_pc,
    output logic              o_flush,
    output logic              o_load_pc,
    output logic              o_read_reg_pc,
    output logic              o_bne,
    output logic              o_blt,
    output logic              o_load_t,
    output logic              o_bex,
    output logic              o_md_start,
    output logic              o_md_is_div,
    output logic              o_md_busy,
    output logic              o_stall,
    output logic              o_exc_valid,
    output logic [DATA_W-1:0] o_exc_code,
    output logic [1:0]        o_md_state
);

    localparam int CW = $clog2(MD_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic            r_md_is_div;
    logic            r_exc_pend;

    logic [4:0] w_op;
    logic [4:0] w_alu;
    logic       w_live;
    logic       w_rtype;
    logic       w_add, w_sub, w_mult, w_div, w_md_op;
    logic       w_j, w_bne, w_jal, w_jr, w_addi, w_blt, w_sw, w_lw, w_setx, w_bex;
    logic       w_timeout;

    assign w_op    = i_instr_dx[31:27];
    assign w_alu   = i_instr_dx[6:2];
    assign w_live  = i_dx_valid & ~i_kill;
    assign w_rtype = w_live & (w_op == 5'd0);

    assign w_add   = w_rtype & (w_alu == 5'b00000);
    assign w_sub   = w_rtype & (w_alu == 5'b00001);
    assign w_mult  = w_rtype & (w_alu == 5'b00110);
    assign w_div   = w_rtype & (w_alu == 5'b00111);
    assign w_md_op = w_mult | w_div;

    assign w_j     = w_live & (w_op == 5'd1);
    assign w_bne   = w_live & (w_op == 5'd2);
    assign w_jal   = w_live & (w_op == 5'd3);
    assign w_jr    = w_live & (w_op == 5'd4);
    assign w_addi  = w_live & (w_op == 5'd5);
    assign w_blt   = w_live & (w_op == 5'd6);
    assign w_sw    = w_live & (w_op == 5'd7);
    assign w_lw    = w_live & (w_op == 5'd8);
    assign w_setx  = w_live & (w_op == 5'd21);
    assign w_bex   = w_live & (w_op == 5'd22);

    assign o_immediate   = w_addi | w_lw | w_sw;
    assign o_j_extend    = w_j | w_jal | w_setx | w_bex;
    assign o_write_pc    = w_j | w_jal | w_jr;
    assign o_flush       = w_j | w_jal | w_jr;
    assign o_load_pc     = w_jal;
    assign o_read_reg_pc = w_jr;
    assign o_bne         = w_bne;
    assign o_blt         = w_blt;
    assign o_load_t      = w_setx;
    assign o_bex         = w_bex;

    assign o_md_is_div = r_md_is_div;
    assign o_md_state  = r_state;
    assign w_timeout   = (r_count == CW'(MD_TIMEOUT - 1));

    // kill outranks md_rdy and the watchdog; in DONE it also suppresses the exception.
    always_comb begin
        w_state_nxt = r_state;
        o_md_start  = 1'b0;
        o_md_busy   = 1'b0;
        o_stall     = 1'b0;
        o_exc_valid = 1'b0;
        o_exc_code  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_md_op) begin
                    o_md_start  = 1'b1;
                    o_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                end else if (i_alu_ovf & (w_add | w_addi | w_sub)) begin
                    o_exc_valid = 1'b1;
                    o_exc_code  = w_add  ? DATA_W'(EXC_ADD)  :
                                  w_addi ? DATA_W'(EXC_ADDI) : DATA_W'(EXC_SUB);
                end
            end
            S_BUSY: begin
                o_md_busy = 1'b1;
                if (i_kill) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    o_stall = 1'b1;
                    if (i_md_rdy || w_timeout) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                if (~i_kill & (r_exc_pend | i_md_exc)) begin
                    o_exc_valid = 1'b1;
                    o_exc_code  = r_md_is_div ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MUL);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_md_is_div <= 1'b0;
            r_exc_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (o_md_start) begin
                r_count     <= '0;
                r_md_is_div <= w_div;
                r_exc_pend  <= 1'b0;
            end else if (r_state == S_BUSY) begin
                r_count <= r_count + CW'(1);
                // Remember the failure cause so DONE can report it after md_rdy drops.
                if (~i_kill & i_md_rdy) begin
                    r_exc_pend <= i_md_exc;
                end else if (~i_kill & w_timeout) begin
                    r_exc_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dx_multdiv_ctrl.sv
// Directed bench for dx_multdiv_ctrl: each driven cycle pushes its hand-computed expected
// output vector; a negedge monitor pops and compares.
module tb_dx_multdiv_ctrl;

    localparam int DW = 32;

    // Expected-flag bit positions
    localparam logic [14:0] M_IMM   = 15'h4000;
    localparam logic [14:0] M_JEXT  = 15'h2000;
    localparam logic [14:0] M_WPC   = 15'h1000;
    localparam logic [14:0] M_FLUSH = 15'h0800;
    localparam logic [14:0] M_LPC   = 15'h0400;
    localparam logic [14:0] M_RRPC  = 15'h0200;
    localparam logic [14:0] M_BNE   = 15'h0100;
    localparam logic [14:0] M_BLT   = 15'h0080;
    localparam logic [14:0] M_LDT   = 15'h0040;
    localparam logic [14:0] M_BEX   = 15'h0020;
    localparam logic [14:0] M_START = 15'h0010;
    localparam logic [14:0] M_DIV   = 15'h0008;
    localparam logic [14:0] M_BUSY  = 15'h0004;
    localparam logic [14:0] M_STALL = 15'h0002;
    localparam logic [14:0] M_EXC   = 15'h0001;
    localparam logic [14:0] M_NONE  = 15'h0000;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] instr_dx;
    logic          dx_valid, kill, alu_ovf, md_rdy, md_exc;
    logic          immediate, j_extend, write_pc, flush, load_pc, read_reg_pc;
    logic          bne, blt, load_t, bex, md_start, md_is_div, md_busy, stall, exc_valid;
    logic [DW-1:0] exc_code;
    logic [1:0]    md_state;

    logic [DW+14:0] exp_q[$];
    string          name_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;

    dx_multdiv_ctrl #(
        .DATA_W(DW), .EXC_ADD(1), .EXC_ADDI(2), .EXC_SUB(3),
        .EXC_MUL(4), .EXC_DIV(5), .MD_TIMEOUT(8)
    ) dut (
        .i_clock(clock), .i_reset(reset), .i_instr_dx(instr_dx), .i_dx_valid(dx_valid),
        .i_kill(kill), .i_alu_ovf(alu_ovf), .i_md_rdy(md_rdy), .i_md_exc(md_exc),
        .o_immediate(immediate), .o_j_extend(j_extend), .o_write_pc(write_pc),
        .o_flush(flush), .o_load_pc(load_pc), .o_read_reg_pc(read_reg_pc),
        .o_bne(bne), .o_blt(blt), .o_load_t(load_t), .o_bex(bex),
        .o_md_start(md_start), .o_md_is_div(md_is_div), .o_md_busy(md_busy),
        .o_stall(stall), .o_exc_valid(exc_valid), .o_exc_code(exc_code),
        .o_md_state(md_state)
    );

    // Clock and reset
    always #5 clock = ~clock;

    // Monitor / scoreboard
    always @(negedge clock) begin
        logic [DW+14:0] got, want;
        string          nm;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {immediate, j_extend, write_pc, flush, load_pc, read_reg_pc, bne, blt,
                    load_t, bex, md_start, md_is_div, md_busy, stall, exc_valid, exc_code};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got flags=%b code=%0d, expected flags=%b code=%0d",
                         nm, got[DW+14:DW], got[DW-1:0], want[DW+14:DW], want[DW-1:0]);
            end
        end
    end

    function automatic logic [DW-1:0] r_ins(input logic [4:0] alu);
        return {5'd0, 20'd0, alu, 2'b00};
    endfunction

    function automatic logic [DW-1:0] i_ins(input logic [4:0] op);
        return {op, 27'd0};
    endfunction

    // Driver: apply one cycle of inputs and queue the expected outputs for that cycle
    task automatic step(input string nm, input logic rst, input logic [DW-1:0] ins,
                        input logic v, input logic k, input logic ovf, input logic rdy,
                        input logic mexc, input logic [14:0] fl, input logic [DW-1:0] code);
        reset    = rst;
        instr_dx = ins;
        dx_valid = v;
        kill     = k;
        alu_ovf  = ovf;
        md_rdy   = rdy;
        md_exc   = mexc;
        exp_q.push_back({fl, code});
        name_q.push_back(nm);
        @(posedge clock);
        #1;
    endtask

    logic [DW-1:0] ADD, SUB, MUL, DIV, ADDI, LW, SW, J, JAL, JR, BNE, BLT, SETX, BEX, NOP;

    initial begin
        ADD  = r_ins(5'b00000);
        SUB  = r_ins(5'b00001);
        MUL  = r_ins(5'b00110);
        DIV  = r_ins(5'b00111);
        J    = i_ins(5'd1);
        BNE  = i_ins(5'd2);
        JAL  = i_ins(5'd3);
        JR   = i_ins(5'd4);
        ADDI = i_ins(5'd5);
        BLT  = i_ins(5'd6);
        SW   = i_ins(5'd7);
        LW   = i_ins(5'd8);
        SETX = i_ins(5'd21);
        BEX  = i_ins(5'd22);
        NOP  = '0;

        reset = 1'b1; instr_dx = '0; dx_valid = 1'b0; kill = 1'b0;
        alu_ovf = 1'b0; md_rdy = 1'b0; md_exc = 1'b0;
        @(posedge clock);
        #1;

        //   name            rst ins   v  k  ovf rdy mexc flags                              code
        step("reset",        1, NOP,  0, 0, 0, 0, 0, M_NONE, 0);
        step("idle",         0, NOP,  0, 0, 0, 0, 0, M_NONE, 0);
        // ALU overflow exceptions
        step("add_ovf",      0, ADD,  1, 0, 1, 0, 0, M_EXC, 1);
        step("addi_ovf",     0, ADDI, 1, 0, 1, 0, 0, M_IMM | M_EXC, 2);
        step("sub_ovf",      0, SUB,  1, 0, 1, 0, 0, M_EXC, 3);
        step("add_noovf",    0, ADD,  1, 0, 0, 0, 0, M_NONE, 0);
        step("add_ovf_bub",  0, ADD,  0, 0, 1, 0, 0, M_NONE, 0);
        step("add_ovf_kill", 0, ADD,  1, 1, 1, 0, 0, M_NONE, 0);
        step("lw_ovf",       0, LW,   1, 0, 1, 0, 0, M_IMM, 0);
        // Decode
        step("jal",          0, JAL,  1, 0, 0, 0, 0, M_JEXT | M_WPC | M_FLUSH | M_LPC, 0);
        step("jal_bubble",   0, JAL,  0, 0, 0, 0, 0, M_NONE, 0);
        step("jal_kill",     0, JAL,  1, 1, 0, 0, 0, M_NONE, 0);
        step("j",            0, J,    1, 0, 0, 0, 0, M_JEXT | M_WPC | M_FLUSH, 0);
        step("jr",           0, JR,   1, 0, 0, 0, 0, M_WPC | M_FLUSH | M_RRPC, 0);
        step("bne",          0, BNE,  1, 0, 0, 0, 0, M_BNE, 0);
        step("blt",          0, BLT,  1, 0, 0, 0, 0, M_BLT, 0);
        step("sw",           0, SW,   1, 0, 0, 0, 0, M_IMM, 0);
        step("setx",         0, SETX, 1, 0, 0, 0, 0, M_JEXT | M_LDT, 0);
        step("bex",          0, BEX,  1, 0, 0, 0, 0, M_JEXT | M_BEX, 0);
        // mult, md_rdy on the 5th BUSY cycle
        step("mul_start",    0, MUL,  1, 0, 0, 0, 0, M_START | M_STALL, 0);
        for (int i = 0; i < 4; i++)
            step("mul_busy",  0, MUL,  1, 0, 0, 0, 0, M_BUSY | M_STALL, 0);
        step("mul_busy_rdy", 0, MUL,  1, 0, 0, 1, 0, M_BUSY | M_STALL, 0);
        step("mul_done",     0, MUL,  1, 0, 0, 0, 0, M_NONE, 0);
        step("mul_after",    0, NOP,  0, 0, 0, 0, 0, M_NONE, 0);
        // div with md_exc
        step("div_start",    0, DIV,  1, 0, 0, 0, 0, M_START | M_STALL, 0);
        step("div_rdy_exc",  0, DIV,  1, 0, 0, 1, 1, M_DIV | M_BUSY | M_STALL, 0);
        step("div_done_exc", 0, DIV,  1, 0, 0, 0, 0, M_DIV | M_EXC, 5);
        step("div_after",    0, NOP,  0, 0, 0, 0, 0, M_DIV, 0);
        // div watchdog timeout after 8 BUSY cycles
        step("to_start",     0, DIV,  1, 0, 0, 0, 0, M_DIV | M_START | M_STALL, 0);
        for (int i = 0; i < 8; i++)
            step("to_busy",   0, DIV,  1, 0, 0, 0, 0, M_DIV | M_BUSY | M_STALL, 0);
        step("to_done",      0, DIV,  1, 0, 0, 0, 0, M_DIV | M_EXC, 5);
        step("to_after",     0, NOP,  0, 0, 0, 0, 0, M_DIV, 0);
        // Back-to-back mult: second start in the IDLE after DONE, then killed in BUSY
        step("b2b_start1",   0, MUL,  1, 0, 0, 0, 0, M_DIV | M_START | M_STALL, 0);
        step("b2b_busy1",    0, MUL,  1, 0, 0, 1, 0, M_BUSY | M_STALL, 0);
        step("b2b_done1",    0, MUL,  1, 0, 0, 0, 0, M_NONE, 0);
        step("b2b_start2",   0, MUL,  1, 0, 0, 0, 0, M_START | M_STALL, 0);
        step("kill_busy1",   0, MUL,  1, 0, 0, 0, 0, M_BUSY | M_STALL, 0);
        step("kill_busy2",   0, MUL,  1, 0, 0, 0, 0, M_BUSY | M_STALL, 0);
        step("kill_busy3",   0, MUL,  1, 1, 0, 1, 1, M_BUSY, 0);
        step("kill_after",   0, NOP,  0, 0, 0, 0, 0, M_NONE, 0);
        // kill in DONE suppresses the div exception
        step("kd_start",     0, DIV,  1, 0, 0, 0, 0, M_START | M_STALL, 0);
        step("kd_busy_rdy",  0, DIV,  1, 0, 0, 1, 1, M_DIV | M_BUSY | M_STALL, 0);
        step("kd_done_kill", 0, DIV,  1, 1, 0, 0, 0, M_DIV, 0);
        step("kd_after",     0, NOP,  0, 0, 0, 0, 0, M_DIV, 0);
        // alu_ovf ignored while BUSY
        step("ob_start",     0, MUL,  1, 0, 0, 0, 0, M_DIV | M_START | M_STALL, 0);
        step("ob_busy_ovf",  0, MUL,  1, 0, 1, 0, 0, M_BUSY | M_STALL, 0);
        // Reset held 2 cycles mid-BUSY
        step("rst_busy1",    1, NOP,  0, 0, 0, 0, 0, M_BUSY | M_STALL, 0);
        step("rst_busy2",    1, NOP,  0, 0, 0, 0, 0, M_NONE, 0);
        step("rst_after",    0, NOP,  0, 0, 0, 0, 0, M_NONE, 0);
        step("rst_add_ovf",  0, ADD,  1, 0, 1, 0, 0, M_EXC, 1);

        @(negedge clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
